// File: rtl/ex_stage_muldiv.sv
// Execute stage: forwarding muxes, single-cycle ALU and the EXMA pipeline register.
// Define EX_MULDIV_EN to build the iterative MUL/DIVU/REMU engine; without it those ops return 0.
module ex_stage_muldiv #(
    parameter int WIDTH = 32,
    parameter int RDS_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    input  logic [2:0]       i_op,
    input  logic [RDS_W-1:0] i_rds_addr,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [WIDTH-1:0] i_data_mem,
    input  logic [WIDTH-1:0] i_data_wb,
    input  logic [WIDTH-1:0] i_data_vwb,
    input  logic [1:0]       i_fwd1,
    input  logic [1:0]       i_fwd2,
    input  logic             i_flush,
    input  logic             i_stall,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_rslt,
    output logic [RDS_W-1:0] o_rds_addr
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REMU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    function automatic logic [WIDTH-1:0] fwd_sel(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] rs,
        input logic [WIDTH-1:0] mem,
        input logic [WIDTH-1:0] wb,
        input logic [WIDTH-1:0] vwb
    );
        case (sel)
            2'b00:   return rs;
            2'b01:   return mem;
            2'b10:   return wb;
            default: return vwb;
        endcase
    endfunction

    logic [WIDTH-1:0] opnd1;
    logic [WIDTH-1:0] opnd2;
    logic [WIDTH-1:0] alu_rslt;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_rslt;
    logic [RDS_W-1:0] ex_rds;

    assign opnd1 = fwd_sel(i_fwd1, i_rs1, i_data_mem, i_data_wb, i_data_vwb);
    assign opnd2 = fwd_sel(i_fwd2, i_rs2, i_data_mem, i_data_wb, i_data_vwb);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        alu_rslt = '0;
        case (i_op)
            OP_ADD:  alu_rslt = opnd1 + opnd2;
            OP_SUB:  alu_rslt = opnd1 - opnd2;
            OP_AND:  alu_rslt = opnd1 & opnd2;
            OP_OR:   alu_rslt = opnd1 | opnd2;
            OP_XOR:  alu_rslt = opnd1 ^ opnd2;
            default: alu_rslt = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] md_rslt;
    logic [2:0]       lat_op;
    logic [RDS_W-1:0] lat_rds;
    logic             is_multi;
    logic             start;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;

    assign is_multi = (i_op == OP_MUL) || (i_op == OP_DIVU) || (i_op == OP_REMU);
    assign start    = (state == S_IDLE) && i_valid && is_multi && !i_flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (start) state_nxt = (i_op == OP_MUL) ? S_MUL : S_DIV;
                S_MUL, S_DIV: if (cnt == CNT_W'(1)) state_nxt = S_DONE;
                S_DONE:       if (!i_stall) state_nxt = S_IDLE;
                default:      state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = (state != S_IDLE) || ((state == S_IDLE) && i_valid && is_multi) || i_stall;
    end

    // MUL: acc accumulates, op_a shifts left, op_b shifts right. DIV: acc is the partial
    // remainder, op_a the dividend/quotient shift register, op_b the divisor.
    assign rem_sh   = {acc, op_a[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, op_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            lat_op  <= '0;
            lat_rds <= '0;
            cnt     <= '0;
        end else if (start) begin
            op_a    <= opnd1;
            op_b    <= opnd2;
            acc     <= '0;
            lat_op  <= i_op;
            lat_rds <= i_rds_addr;
            cnt     <= CNT_W'(WIDTH);
        end else if (state == S_MUL) begin
            if (op_b[0]) acc <= acc + op_a;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt - CNT_W'(1);
        end else if (state == S_DIV) begin
            if (!rem_diff[WIDTH]) begin
                acc  <= rem_diff[WIDTH-1:0];
                op_a <= {op_a[WIDTH-2:0], 1'b1};
            end else begin
                acc  <= rem_sh[WIDTH-1:0];
                op_a <= {op_a[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_rslt = (lat_op == OP_DIVU) ? op_a : acc;

    always_comb begin
        ex_valid = 1'b0;
        ex_rslt  = '0;
        ex_rds   = '0;
        if (state == S_DONE) begin
            ex_valid = 1'b1;
            ex_rslt  = md_rslt;
            ex_rds   = lat_rds;
        end else if ((state == S_IDLE) && i_valid && !is_multi) begin
            ex_valid = 1'b1;
            ex_rslt  = alu_rslt;
            ex_rds   = i_rds_addr;
        end
    end
`else
    assign o_busy = i_stall;

    always_comb begin
        ex_valid = i_valid;
        ex_rslt  = i_valid ? alu_rslt : '0;
        ex_rds   = i_valid ? i_rds_addr : '0;
    end
`endif

    // EXMA: flush clears, stall holds, otherwise load the result or a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid    <= 1'b0;
            o_rslt     <= '0;
            o_rds_addr <= '0;
        end else if (i_flush) begin
            o_valid    <= 1'b0;
            o_rslt     <= '0;
            o_rds_addr <= '0;
        end else if (!i_stall) begin
            o_valid    <= ex_valid;
            o_rslt     <= ex_rslt;
            o_rds_addr <= ex_rds;
        end
    end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Directed bench for ex_stage_muldiv: a cycle-level model of the stage checked on every
// falling edge, plus hand-computed literal expectations at key points.
module tb_ex_stage_muldiv;
    localparam int W  = 32;
    localparam int RW = 5;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;
    localparam logic [2:0] OP_REMU = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;
`ifdef EX_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          i_valid    = 1'b0;
    logic [2:0]    i_op       = 3'b000;
    logic [RW-1:0] i_rds_addr = '0;
    logic [W-1:0]  i_rs1      = '0;
    logic [W-1:0]  i_rs2      = '0;
    logic [W-1:0]  i_data_mem = '0;
    logic [W-1:0]  i_data_wb  = '0;
    logic [W-1:0]  i_data_vwb = '0;
    logic [1:0]    i_fwd1     = 2'b00;
    logic [1:0]    i_fwd2     = 2'b00;
    logic          i_flush    = 1'b0;
    logic          i_stall    = 1'b0;
    logic          o_busy;
    logic          o_valid;
    logic [W-1:0]  o_rslt;
    logic [RW-1:0] o_rds_addr;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage_muldiv #(.WIDTH(W), .RDS_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (i_valid),
        .i_op       (i_op),
        .i_rds_addr (i_rds_addr),
        .i_rs1      (i_rs1),
        .i_rs2      (i_rs2),
        .i_data_mem (i_data_mem),
        .i_data_wb  (i_data_wb),
        .i_data_vwb (i_data_vwb),
        .i_fwd1     (i_fwd1),
        .i_fwd2     (i_fwd2),
        .i_flush    (i_flush),
        .i_stall    (i_stall),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_rslt     (o_rslt),
        .o_rds_addr (o_rds_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [W-1:0] pick(input logic [1:0] f, input logic [W-1:0] rs,
                                          input logic [W-1:0] mem, input logic [W-1:0] wb,
                                          input logic [W-1:0] vwb);
        case (f)
            2'd0:    return rs;
            2'd1:    return mem;
            2'd2:    return wb;
            default: return vwb;
        endcase
    endfunction

    function automatic bit multi_op(input logic [2:0] op);
        return MD_EN && ((op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU));
    endfunction

    function automatic logic [W-1:0] spec_result(input logic [2:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_MUL:  return MD_EN ? prod[W-1:0] : {W{1'b0}};
            OP_DIVU: return !MD_EN ? {W{1'b0}} : ((b == 0) ? {W{1'b1}} : a / b);
            OP_REMU: return !MD_EN ? {W{1'b0}} : ((b == 0) ? a : a % b);
            default: return {W{1'b0}};
        endcase
    endfunction

    logic          m_valid  = 1'b0;
    logic [W-1:0]  m_rslt   = '0;
    logic [RW-1:0] m_rds    = '0;
    int            eng_left = 0;   // edges until the engine's result loads into EXMA
    logic [W-1:0]  eng_rslt = '0;
    logic [RW-1:0] eng_rds  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset || i_flush) begin
            m_valid  <= 1'b0;
            m_rslt   <= '0;
            m_rds    <= '0;
            eng_left <= 0;
        end else if (eng_left == 0) begin
            if (i_valid && multi_op(i_op)) begin
                eng_left <= W + 1;
                eng_rslt <= spec_result(i_op, pick(i_fwd1, i_rs1, i_data_mem, i_data_wb, i_data_vwb),
                                        pick(i_fwd2, i_rs2, i_data_mem, i_data_wb, i_data_vwb));
                eng_rds  <= i_rds_addr;
                if (!i_stall) m_valid <= 1'b0;
            end else if (!i_stall) begin
                m_valid <= i_valid;
                if (i_valid) begin
                    m_rslt <= spec_result(i_op, pick(i_fwd1, i_rs1, i_data_mem, i_data_wb, i_data_vwb),
                                          pick(i_fwd2, i_rs2, i_data_mem, i_data_wb, i_data_vwb));
                    m_rds  <= i_rds_addr;
                end
            end
        end else if (eng_left == 1) begin
            if (!i_stall) begin
                m_valid  <= 1'b1;
                m_rslt   <= eng_rslt;
                m_rds    <= eng_rds;
                eng_left <= 0;
            end
        end else begin
            eng_left <= eng_left - 1;
            if (!i_stall) m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy", {63'd0, o_busy},
              {63'd0, (eng_left != 0) || (i_valid && multi_op(i_op)) || i_stall});
        check("valid", {63'd0, o_valid}, {63'd0, m_valid});
        if (m_valid) begin
            check("rslt", {32'd0, o_rslt}, {32'd0, m_rslt});
            check("rds", {59'd0, o_rds_addr}, {59'd0, m_rds});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [RW-1:0] rd);
        i_valid    = 1'b1;
        i_op       = op;
        i_rs1      = a;
        i_rs2      = b;
        i_rds_addr = rd;
        i_fwd1     = 2'b00;
        i_fwd2     = 2'b00;
    endtask

    task automatic run_md(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp);
        int edges;
        drive(op, a, b, 5'd9);
        step(1);
        i_valid = 1'b0;
        edges = 1;
        while (o_valid !== 1'b1 && edges < W + 8) begin
            step(1);
            edges++;
        end
        check({nm, "_latency"}, 64'(edges), 64'(W + 2));
        check({nm, "_rslt"}, {32'd0, o_rslt}, {32'd0, exp});
    endtask

    logic [2:0] t_op  [3] = '{OP_AND, OP_OR, OP_XOR};
    logic [W-1:0] t_exp [3] = '{32'h00F0_1200, 32'hFFF0_FF34, 32'hFF00_ED34};

    initial begin
        step(2);
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_rslt", {32'd0, o_rslt}, 64'd0);
        check("rst_rds", {59'd0, o_rds_addr}, 64'd0);
        check("rst_busy", {63'd0, o_busy}, 64'd0);
        reset = 1'b0;

        drive(OP_ADD, 32'hFFFF_FFFF, 32'h1, 5'd3);
        step(1);
        check("add_wrap_valid", {63'd0, o_valid}, 64'd1);
        check("add_wrap_rslt", {32'd0, o_rslt}, 64'd0);

        drive(OP_SUB, 32'h11, 32'h22, 5'd4);
        i_fwd1 = 2'b01; i_data_mem = 32'd7;
        i_fwd2 = 2'b11; i_data_vwb = 32'd5;
        step(1);
        check("sub_fwd_rslt", {32'd0, o_rslt}, 64'd2);

        for (int k = 0; k < 3; k++) begin
            drive(t_op[k], 32'hF0F0_1234, 32'hDEAD_0000, 5'(10 + k));
            i_fwd2 = 2'b10; i_data_wb = 32'h0FF0_FF00;
            step(1);
            check("logic_rslt", {32'd0, o_rslt}, {32'd0, t_exp[k]});
        end

        drive(OP_ADD, 32'd10, 32'd20, 5'd4);
        step(1);
        i_stall = 1'b1;
        drive(OP_XOR, 32'd3, 32'd5, 5'd5);
        step(2);
        check("stall_hold_rslt", {32'd0, o_rslt}, 64'd30);
        check("stall_hold_rds", {59'd0, o_rds_addr}, 64'd4);
        i_stall = 1'b0;
        step(1);
        check("stall_release_rslt", {32'd0, o_rslt}, 64'd6);

        drive(OP_ADD, 32'd1, 32'd1, 5'd9);
        i_stall = 1'b1; i_flush = 1'b1;
        step(1);
        check("flush_valid", {63'd0, o_valid}, 64'd0);
        check("flush_rslt", {32'd0, o_rslt}, 64'd0);
        check("flush_rds", {59'd0, o_rds_addr}, 64'd0);
        i_flush = 1'b0; i_stall = 1'b0; i_valid = 1'b0;
        step(1);

        drive(OP_ADD, 32'd40, 32'd2, 5'd3);
        step(1);
        check("pre_reset_rslt", {32'd0, o_rslt}, 64'd42);
        i_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, o_valid}, 64'd0);
        check("async_rst_rslt", {32'd0, o_rslt}, 64'd0);
        step(1);
        reset = 1'b0;

`ifdef EX_MULDIV_EN
        begin
            int edges;
            int busy_cycles;
            drive(OP_MUL, 32'h0001_0000, 32'h0001_0001, 5'd5);
            #1;
            check("mul_issue_busy", {63'd0, o_busy}, 64'd1);
            step(1);
            drive(OP_ADD, 32'd5, 32'd6, 5'd12);
            edges = 1;
            busy_cycles = 0;
            while (o_valid !== 1'b1 && edges < W + 8) begin
                if (o_busy === 1'b1) busy_cycles++;
                step(1);
                edges++;
            end
            i_valid = 1'b0;
            check("mul_latency", 64'(edges), 64'(W + 2));
            check("mul_busy_cycles", 64'(busy_cycles), 64'(W + 1));
            check("mul_rslt", {32'd0, o_rslt}, 64'h0001_0000);
            check("mul_rds", {59'd0, o_rds_addr}, 64'd5);
        end

        run_md("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_md("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        run_md("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_md("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5);

        drive(OP_DIVU, 32'd1000, 32'd3, 5'd6);
        step(1);
        i_valid = 1'b0;
        step(9);
        i_flush = 1'b1;
        step(1);
        i_flush = 1'b0;
        check("div_flush_valid", {63'd0, o_valid}, 64'd0);
        check("div_flush_busy", {63'd0, o_busy}, 64'd0);
        step(W + 4);
        check("div_flush_no_result", {63'd0, o_valid}, 64'd0);

        drive(OP_MUL, 32'd3, 32'd4, 5'd7);
        step(1);
        i_valid = 1'b0;
        step(W);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("done_stall_hold", {63'd0, o_valid}, 64'd0);
            check("done_stall_busy", {63'd0, o_busy}, 64'd1);
        end
        i_stall = 1'b0;
        step(1);
        check("done_release_valid", {63'd0, o_valid}, 64'd1);
        check("done_release_rslt", {32'd0, o_rslt}, 64'd12);
        check("done_release_rds", {59'd0, o_rds_addr}, 64'd7);

        drive(OP_MUL, 32'd9, 32'd9, 5'd8);
        step(1);
        i_valid = 1'b0;
        step(10);
        #2 reset = 1'b1;
        #1;
        check("mul_rst_busy", {63'd0, o_busy}, 64'd0);
        check("mul_rst_valid", {63'd0, o_valid}, 64'd0);
        step(1);
        reset = 1'b0;
        drive(OP_ADD, 32'd2, 32'd3, 5'd1);
        step(1);
        check("post_rst_add_valid", {63'd0, o_valid}, 64'd1);
        check("post_rst_add_rslt", {32'd0, o_rslt}, 64'd5);
`else
        drive(OP_MUL, 32'd6, 32'd7, 5'd5);
        #1;
        check("nomd_busy", {63'd0, o_busy}, 64'd0);
        step(1);
        check("nomd_mul_valid", {63'd0, o_valid}, 64'd1);
        check("nomd_mul_rslt", {32'd0, o_rslt}, 64'd0);
        drive(OP_DIVU, 32'd5, 32'd0, 5'd6);
        step(1);
        check("nomd_divu_rslt", {32'd0, o_rslt}, 64'd0);
        i_stall = 1'b1;
        #1;
        check("nomd_stall_busy", {63'd0, o_busy}, 64'd1);
        i_stall = 1'b0;
        drive(OP_ADD, 32'd2, 32'd3, 5'd1);
        step(1);
        check("nomd_add_rslt", {32'd0, o_rslt}, 64'd5);
`endif
        i_valid = 1'b0;
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ex_stage_muldiv.md
EX_STAGE_MULDIV -- requirements
Module: ex_stage_muldiv

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width (>=8, even).
REQ-002 SHALL have parameter: RDS_W, 5, destination register address width.
REQ-003 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: i_valid in 1 instruction present; i_op in 3 operation; i_rds_addr in RDS_W destination.
REQ-006 SHALL have ports: i_rs1, i_rs2 in WIDTH register operands; i_data_mem, i_data_wb, i_data_vwb in WIDTH forwarded data.
REQ-007 SHALL have ports: i_fwd1, i_fwd2 in 2 forward select; i_flush in 1 clear EXMA; i_stall in 1 hold EXMA.
REQ-008 SHALL have ports: o_busy out 1 stall request to IDEX; o_valid out 1, o_rslt out WIDTH, o_rds_addr out RDS_W (EXMA register).

Function
REQ-009 SHALL select each operand by fwd: 00 rs, 01 mem, 10 wb, 11 vwb.
REQ-010 SHALL decode i_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 111 XOR (single-cycle); 100 MUL low WIDTH bits, 101 DIVU, 110 REMU (multi-cycle).
REQ-011 SHALL wrap ADD/SUB/MUL modulo 2^WIDTH; all operands unsigned.
REQ-012 SHALL load a single-cycle result into EXMA on the edge after issue when i_stall=0 and i_flush=0 (latency 1).
REQ-013 SHALL implement FSM IDLE->MUL|DIV->DONE->IDLE; IDLE->MUL/DIV on i_valid with multi-cycle op, latching operands, i_op, i_rds_addr, counter=WIDTH.
REQ-014 SHALL perform one shift-add (MUL) or restoring-division (DIV) step per cycle, decrementing counter; exit to DONE after exactly WIDTH steps.
REQ-015 SHALL in DONE load EXMA with result when i_stall=0 and go IDLE; remain in DONE while i_stall=1.
REQ-016 SHALL make multi-cycle result visible on o_valid/o_rslt after the (WIDTH+2)th edge, counting the issue edge as first.
REQ-017 SHALL drive o_busy = (state!=IDLE) | (state==IDLE & i_valid & multi-cycle op) | i_stall, combinationally.
REQ-018 SHALL ignore i_valid/operands while state!=IDLE.
REQ-019 SHALL give DIVU by zero quotient all-ones, REMU by zero remainder = dividend.
REQ-020 SHALL on i_flush clear o_valid, o_rslt, o_rds_addr next edge and force FSM to IDLE, aborting any operation; flush overrides stall and issue.
REQ-021 SHALL on i_stall=1 hold EXMA contents unchanged; FSM MUL/DIV stepping continues during stall.
REQ-022 SHALL load EXMA with o_valid=0 when i_valid=0 in IDLE and i_stall=0 (bubble).

Reset
REQ-023 SHALL on reset asynchronously set o_valid=0, o_rslt=0, o_rds_addr=0, FSM=IDLE, counter=0, latched operands=0.
REQ-024 SHALL abort an in-flight operation on reset; o_busy follows REQ-017 from reset state.

Configuration
REQ-025 SHALL compile the MUL/DIV FSM and datapath only when EX_MULDIV_EN is defined.
REQ-026 SHALL without EX_MULDIV_EN treat ops 100/101/110 as single-cycle returning 0, with o_busy = i_stall and no FSM state.

Verification
REQ-027 SHALL check: WIDTH=32, ADD 0xFFFFFFFF+1, fwd 00 -> o_rslt=0, o_valid=1 one edge later.
REQ-028 SHALL check: fwd1=01 i_data_mem=7, fwd2=11 i_data_vwb=5, SUB -> o_rslt=2.
REQ-029 SHALL check: MUL 0x10000 x 0x10001 -> o_rslt=0x00010000 after 34th edge; o_busy high 33 cycles.
REQ-030 SHALL check: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
REQ-031 SHALL check: i_flush at step 10 of DIVU -> FSM IDLE, o_valid=0, o_busy=0 next cycle; i_stall held 3 cycles in DONE -> result appears 3 edges later, EXMA unchanged meanwhile.
REQ-032 SHALL check: reset asserted mid-MUL between edges -> outputs 0 immediately, new ADD accepted after deassert.
